// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg -- shared definitions for the HI/LO multiply/divide unit.
//
// Contents:
//   op_e      : operation codes driven on hilo_muldiv.op
//   state_e   : hilo_muldiv control states
//   CNT_LAST  : iteration counter value of the final shift/add step
//   magnitude : absolute value of a 32-bit operand, signed or unsigned
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // 32 iterations, counter runs 0..31.
    localparam logic [4:0] CNT_LAST = 5'd31;

    // The operand is widened to 33 bits before negation so that 0x80000000
    // yields +2^31 rather than overflowing back to itself.
    function automatic logic [31:0] magnitude(input logic [31:0] x,
                                              input logic        is_signed);
        logic [32:0] ext;
        ext = {is_signed & x[31], x};
        if (ext[32]) begin
            ext = -ext;
        end
        return ext[31:0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- iterative unsigned multiply / restoring divide datapath.
//
// Holds the 64-bit shift register, the 33-bit adder/subtractor and the 5-bit
// iteration counter. Operates on magnitudes only; signs are handled by the
// parent.
//
// Configuration macro: HILO_MULDIV_DIV_EN -- when undefined the divide path
// (and the i_is_div port) is removed and only multiplication is built.
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (counter only)
//   i_load         : capture operands, clear counter
//   i_step         : perform one iteration
//   i_is_div       : operation being loaded is a division (divide build only)
//   i_mag_a        : multiplicand / dividend magnitude
//   i_mag_b        : multiplier / divisor magnitude
//   o_last         : current step is the 32nd iteration
//   o_result       : multiply: 64-bit product; divide: {remainder, quotient}
// -----------------------------------------------------------------------------
module muldiv_iter
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_step,
`ifdef HILO_MULDIV_DIV_EN
    input  logic        i_is_div,
`endif
    input  logic [31:0] i_mag_a,
    input  logic [31:0] i_mag_b,
    output logic        o_last,
    output logic [63:0] o_result
);

    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic [4:0]  r_cnt;
    logic [63:0] w_next;

`ifdef HILO_MULDIV_DIV_EN
    logic        r_is_div;
    logic [32:0] w_add_a;
    logic [32:0] w_add_b;
    logic        w_cin;
    logic [33:0] w_sum;

    // One adder serves both operations. Multiply adds the multiplicand into
    // the upper half when the current multiplier bit is set. Divide subtracts
    // the divisor from the shifted partial remainder; the carry out is the
    // "no borrow" flag that decides the quotient bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_add_a = {1'b0, r_acc[63:32]};
        w_add_b = {1'b0, (r_acc[0] ? r_opb : 32'd0)};
        w_cin   = 1'b0;
        if (r_is_div) begin
            w_add_a = r_acc[63:31];
            w_add_b = ~{1'b0, r_opb};
            w_cin   = 1'b1;
        end
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {33'd0, w_cin};

    // Divide: on borrow keep the shifted remainder (restore), else take the
    // difference; the quotient bit enters at the bottom.
    assign w_next = r_is_div
                  ? (w_sum[33] ? {w_sum[31:0], r_acc[30:0], 1'b1}
                               : {r_acc[62:0], 1'b0})
                  : {w_sum[32:0], r_acc[31:1]};
`else
    logic [32:0] w_sum;

    assign w_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
    assign w_next = {w_sum, r_acc[31:1]};
`endif

    // NOTE: the datapath registers carry no reset; they are always loaded
    // before use, and only the control state needs a defined reset value.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_acc    <= {32'd0, i_mag_a};
            r_opb    <= i_mag_b;
`ifdef HILO_MULDIV_DIV_EN
            r_is_div <= i_is_div;
`endif
        end else if (i_step) begin
            r_acc <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_cnt <= 5'd0;
        end else if (i_load) begin
            r_cnt <= 5'd0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_last   = i_step && (r_cnt == CNT_LAST);
    assign o_result = r_acc;

endmodule

// File: rtl/hilo_muldiv.sv
// -----------------------------------------------------------------------------
// hilo_muldiv -- MIPS HI/LO register pair with iterative multiply/divide.
//
// Control FSM, sign fixup and the architectural HI/LO registers. The iterative
// datapath lives in muldiv_iter. A mult/div takes 34 cycles from acceptance
// (cycle 0) to the done pulse (cycle 34); MTHI/MTLO write in one edge.
//
// Configuration macro: HILO_MULDIV_DIV_EN -- when undefined, DIV/DIVU are
// accepted as no-ops and no divider hardware is built.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   start  : request a new operation (sampled only in IDLE)
//   op     : operation code (mips_pkg::op_e)
//   a      : rs operand (multiplicand / dividend / MTHI-MTLO source)
//   b      : rt operand (multiplier / divisor)
//   cancel : abandon the in-flight operation; beats start
//   busy   : operation in flight
//   done   : one-cycle pulse when a mult/div result commits
//   hi, lo : architectural HI/LO values
// -----------------------------------------------------------------------------
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e      r_state;
    state_e      w_next_state;
    op_e         w_op;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_signed;
    logic        w_load;
    logic        w_step;
    logic        w_last;
    logic [63:0] w_result;
    logic [63:0] w_prod;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        r_neg_q;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    assign w_op     = op_e'(op);
    assign w_accept = (r_state == ST_IDLE) && start && !cancel;
    assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_step   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && !cancel;

`ifdef HILO_MULDIV_DIV_EN
    logic        w_is_div;
    logic        r_is_div;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [31:0] r_a;

    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_load   = w_accept && (w_is_mul || w_is_div);
`else
    assign w_load   = w_accept && w_is_mul;
`endif

    muldiv_iter u_iter (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_load),
        .i_step   (w_step),
`ifdef HILO_MULDIV_DIV_EN
        .i_is_div (w_is_div),
`endif
        .i_mag_a  (magnitude(a, w_signed)),
        .i_mag_b  (magnitude(b, w_signed)),
        .o_last   (w_last),
        .o_result (w_result)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_next_state = ST_MUL;
                end
`ifdef HILO_MULDIV_DIV_EN
                else if (w_accept && w_is_div) begin
                    w_next_state = ST_DIV;
                end
`endif
            end
            ST_MUL, ST_DIV: begin
                if (cancel) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Result signs are captured at acceptance since a/b may change afterwards.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_neg_q    <= w_signed & (a[31] ^ b[31]);
`ifdef HILO_MULDIV_DIV_EN
            r_is_div   <= w_is_div;
            r_neg_r    <= w_signed & a[31];
            r_div_zero <= (b == '0);
            r_a        <= a;
`endif
        end
    end

    // ---------------------------------------------------------- sign fixup
    assign w_prod = r_neg_q ? -w_result : w_result;

    always_comb begin
        w_fix_hi = w_prod[63:32];
        w_fix_lo = w_prod[31:0];
`ifdef HILO_MULDIV_DIV_EN
        if (r_is_div) begin
            if (r_div_zero) begin
                // Divide by zero returns the raw dividend, no sign fixup.
                w_fix_hi = r_a;
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                w_fix_hi = r_neg_r ? -w_result[63:32] : w_result[63:32];
                w_fix_lo = r_neg_q ? -w_result[31:0]  : w_result[31:0];
            end
        end
`endif
    end

    // ------------------------------------------------------------- HI / LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX) && !cancel;
            if (w_accept && (w_op == OP_MTHI)) begin
                r_hi <= a;
            end else if (w_accept && (w_op == OP_MTLO)) begin
                r_lo <= a;
            end else if ((r_state == ST_FIX) && !cancel) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv -- directed self-checking bench for hilo_muldiv.
// Inputs are driven and outputs sampled on the falling edge; the rising edge
// at the end of cycle N moves the design into cycle N+1.
// DIV/DIVU expectations follow HILO_MULDIV_DIV_EN.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents a start in the current cycle; returns in the following cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Full mult/div: start in cycle 0, busy through 1..33, result in 34.
    // Returns positioned in cycle 34 so a follow-on start is back-to-back.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int bad_cyc;
        bad_cyc = 0;
        issue(o, x, y);
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_cyc++;
            tick();
        end
        check({tag, " busy_cyc1_33"}, bad_cyc, 0);
        check({tag, " busy_cyc34"}, busy, 0);
        check({tag, " done_cyc34"}, done, 1);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    // Counts cycles with done or busy high over a window.
    task automatic quiet_window(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        check({tag, " quiet"}, seen, 0);
    endtask

    initial begin
        logic [2:0] rst_op;

        // ---------------- reset
        ticks(3);
        reset = 1'b0;
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);

        // reset dominates start
        reset = 1'b1;
        issue(OP_MTHI, 32'hFFFF_0000, 32'd0);
        reset = 1'b0;
        check("rst_vs_start hi", hi, 0);
        check("rst_vs_start busy", busy, 0);

        // ---------------- MTHI / MTLO
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo", lo, 0);
        check("mthi busy", busy, 0);
        check("mthi done", done, 0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi", hi, 32'h1234_5678);

        // ---------------- multiply, back-to-back chain
        run_op("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult -1*5", OP_MULT, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_op("multu 2^31*2", OP_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);
        run_op("mult min*1", OP_MULT, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        tick();
        check("done_pulse_width", done, 0);

        // ---------------- MTLO while busy is ignored
        issue(OP_MULT, 32'd3, 32'd4);       // cycle 1
        ticks(4);                           // cycle 5
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0); // cycle 6
        check("mtlo_busy still_busy", busy, 1);
        check("mtlo_busy lo_untouched", lo, 32'h8000_0000);
        ticks(28);                          // cycle 34
        check("mtlo_busy done", done, 1);
        check("mtlo_busy lo", lo, 32'd12);
        check("mtlo_busy hi", hi, 32'd0);
        tick();

        // ---------------- cancel mid-multiply
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        issue(OP_MULT, 32'd3, 32'd5);       // cycle 1
        ticks(9);                           // cycle 10
        cancel = 1'b1;
        tick();                             // cycle 11
        cancel = 1'b0;
        check("cancel busy_cyc11", busy, 0);
        quiet_window("cancel", 30);
        check("cancel hi", hi, 32'h1234_5678);
        check("cancel lo", lo, 32'd12);

        // cancel suppresses a same-cycle MTHI
        cancel = 1'b1;
        issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
        cancel = 1'b0;
        check("cancel_mthi hi", hi, 32'h1234_5678);

        // cancel beats a same-cycle MULT start
        cancel = 1'b1;
        issue(OP_MULT, 32'd9, 32'd9);
        cancel = 1'b0;
        check("cancel_start busy", busy, 0);
        quiet_window("cancel_start", 36);

        // cancel while in FIX
        issue(OP_MULT, 32'd2, 32'd3);       // cycle 1
        ticks(32);                          // cycle 33
        check("cancel_fix busy_cyc33", busy, 1);
        cancel = 1'b1;
        tick();                             // cycle 34
        cancel = 1'b0;
        check("cancel_fix busy", busy, 0);
        check("cancel_fix done", done, 0);
        check("cancel_fix hi", hi, 32'h1234_5678);
        check("cancel_fix lo", lo, 32'd12);
        tick();
        check("cancel_fix done_late", done, 0);

        // ---------------- divide
`ifdef HILO_MULDIV_DIV_EN
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        tick();
        rst_op = OP_DIV;
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_off busy", busy, 0);
        quiet_window("div_off", 40);
        issue(OP_DIVU, 32'd5, 32'd0);
        quiet_window("divu_off", 40);
        check("div_off hi", hi, 32'h1234_5678);
        check("div_off lo", lo, 32'd12);
        rst_op = OP_MULT;
`endif

        // ---------------- reset in the middle of an operation
        issue(rst_op, 32'd100, 32'd7);      // cycle 1
        ticks(19);                          // cycle 20
        reset = 1'b1;
        tick();                             // cycle 21
        reset = 1'b0;
        check("midrst hi", hi, 0);
        check("midrst lo", lo, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        quiet_window("midrst", 40);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have one parameter, XLEN, default 32: the operand and HI/LO register width; only 32 is supported.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port op, input, 3 bits: operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-007 The block SHALL have port a, input, 32 bits: rs operand, which is the dividend/multiplicand, or the MTHI/MTLO source.
REQ-008 The block SHALL have port b, input, 32 bits: rt operand, which is the divisor/multiplier.
REQ-009 The block SHALL have port cancel, input, 1 bit: abandon any in-flight operation (pipeline flush).
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight, and the ID stage stalls mfhi/mflo and new mult/div while it is high.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a mult/div result commits.
REQ-012 The block SHALL have ports hi and lo, outputs, 32 bits each: architectural HI/LO values, read by mfhi/mflo forwarding.

Function
REQ-013 The block SHALL implement the states IDLE, MUL, DIV and FIX; start SHALL be sampled only in IDLE, and start while busy SHALL be ignored.
REQ-014 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge, stay in IDLE, assert neither busy nor done, and leave the other register unchanged.
REQ-015 MULT/MULTU accepted in cycle 0 SHALL run 32 shift-add iterations (cycles 1..32) on unsigned magnitudes (signed for MULT), then FIX in cycle 33.
REQ-016 DIV/DIVU SHALL run 32 restoring-division iterations (cycles 1..32) on magnitudes, then FIX in cycle 33.
REQ-017 busy SHALL be 1 in cycles 1..33 and 0 in cycle 34; hi/lo SHALL hold the new result and done SHALL be 1 in cycle 34 only.
REQ-018 FIX SHALL negate the 64-bit product when sign(a)^sign(b) for MULT; for DIV, the quotient sign SHALL be sign(a)^sign(b) and the remainder sign SHALL be sign(a).
REQ-019 Results SHALL be LO = product[31:0] and HI = product[63:32]; for division, LO = quotient and HI = remainder.
REQ-020 Divide by zero (DIV or DIVU) SHALL still take 34 cycles and SHALL yield HI=a and LO=0xFFFFFFFF, with sign fixup bypassed.
REQ-021 The most-negative operand (0x80000000) SHALL be handled via a 33-bit magnitude, with no overflow trap; DIV 0x80000000/-1 SHALL give LO=0x80000000 and HI=0.
REQ-022 cancel SHALL have priority over start in the same cycle.
REQ-023 cancel in MUL, DIV or FIX SHALL return the block to IDLE at the next edge, with busy=0 and no done pulse.
REQ-024 A cancelled operation SHALL leave hi/lo unchanged, and a cancel issued in the same cycle as an MTHI/MTLO start SHALL suppress that write.
REQ-025 Once the block is back in IDLE in cycle 34, a start in that same cycle SHALL be accepted, giving back-to-back operations.

Reset
REQ-026 Reset SHALL force: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-028 Reset SHALL dominate cancel and start.

Configuration
REQ-029 The divide path SHALL be controlled by the macro HILO_MULDIV_DIV_EN.
REQ-030 With HILO_MULDIV_DIV_EN defined, DIV/DIVU SHALL behave as in REQ-016 through REQ-021.
REQ-031 Without HILO_MULDIV_DIV_EN, the divider datapath SHALL be absent, and DIV/DIVU SHALL be treated as a no-op: hi/lo unchanged, busy=0, done=0.

Structure
REQ-032 The op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and the state encodings SHALL live in shared package mips_pkg.
REQ-033 One sub-module, muldiv_iter, SHALL hold the 64-bit shift register, the 33-bit adder/subtractor and the 5-bit iteration counter.
REQ-034 The FSM, sign fixup and HI/LO registers SHALL remain in hilo_muldiv.

Verification
REQ-035 MULT a=7, b=0xFFFFFFFD -> done in cycle 34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1..33.
REQ-036 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF.
REQ-038 MTHI a=0x12345678, then MULT started and cancelled at cycle 10 -> busy=0 in cycle 11, no done, hi=0x12345678.
REQ-039 MTLO issued while busy -> ignored, and lo receives only the mult result.
REQ-040 Reset asserted at cycle 20 of a DIV -> hi=lo=0 and busy=0 next cycle; a start in cycle 34 simultaneous with done -> second operation accepted.
